// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator, one DATA_WIDTH-bit frame per start.
// Ports: clk, rst_n | start, tx_data in | busy, done, rx_data out |
//        ss, sclk, mosi out, miso in. Build option: SPI_LSB_FIRST_EN
//        selects LSB-first order for both transmit and receive.
module spi_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  ss,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int PH_W  = $clog2(CLK_DIV) + 1;

  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(DATA_WIDTH - 1);
  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    FINISH
  } state_e;

  state_e                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    ss_q, ss_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    phase_end;
  logic                    accept;
  logic                    first_bit;
  logic                    next_bit;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;

`ifdef SPI_LSB_FIRST_EN
  assign first_bit = tx_data[0];
  assign next_bit  = tx_sh_q[1];
  assign tx_shift  = tx_sh_q >> 1;
  assign rx_shift  = {miso, rx_sh_q[DATA_WIDTH-1:1]};
`else
  assign first_bit = tx_data[DATA_WIDTH-1];
  assign next_bit  = tx_sh_q[DATA_WIDTH-2];
  assign tx_shift  = tx_sh_q << 1;
  assign rx_shift  = {rx_sh_q[DATA_WIDTH-2:0], miso};
`endif

  assign phase_end = (phase_q == PH_LAST);

  // FINISH counts as idle so a start in the done cycle
  // chains frames with a single ss-high cycle.
  assign accept = start &&
    (state_q == IDLE || state_q == FINISH);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = SCLK_HI;
          sclk_d  = 1'b1;
          rx_sh_d = rx_shift;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      SCLK_HI: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = SCLK_LO;
          sclk_d  = 1'b0;
          // Past the last bit mosi just holds.
          if (bit_q != BIT_LAST) begin
            mosi_d  = next_bit;
            tx_sh_d = tx_shift;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      SCLK_LO: begin
        if (phase_end) begin
          phase_d = '0;
          if (bit_q < BIT_LAST) begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = SCLK_HI;
            sclk_d  = 1'b1;
            rx_sh_d = rx_shift;
          end else begin
            bit_d     = '0;
            state_d   = FINISH;
            ss_d      = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            mosi_d    = 1'b0;
            rx_data_d = rx_sh_q;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = SETUP;
      phase_d = '0;
      bit_d   = '0;
      tx_sh_d = tx_data;
      rx_sh_d = '0;
      mosi_d  = first_bit;
      ss_d    = 1'b0;
      sclk_d  = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for spi_controller.
// Default 32-bit/div-4 instance plus an 8-bit/div-1 instance.
module tb_spi_controller;

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [31:0] tx_data = '0;
  logic        busy, done, ss, sclk, mosi, miso;
  logic [31:0] rx_data;

  logic        start2 = 1'b0;
  logic [7:0]  tx2 = '0;
  logic        busy2, done2, ss2, sclk2, mosi2, miso2;
  logic [7:0]  rx2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] tx;
    logic [31:0] rx;
  } exp_t;
  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp8_t;

  exp_t  sb[$];
  exp8_t sb2[$];

  logic [31:0] miso_word  = '0;
  logic [7:0]  miso_word2 = '0;
  int          falls  = 0;
  int          falls2 = 0;

  always #5 clk = ~clk;

  spi_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .ss      (ss),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso)
  );

  spi_controller #(
    .DATA_WIDTH (8),
    .CLK_DIV    (1)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start2),
    .tx_data (tx2),
    .busy    (busy2),
    .done    (done2),
    .rx_data (rx2),
    .ss      (ss2),
    .sclk    (sclk2),
    .mosi    (mosi2),
    .miso    (miso2)
  );

  // Peripheral model: bit index = sclk falls seen in this frame.
  function automatic logic pbit(input logic [63:0] w,
                                input int idx, input int n);
    if (idx >= n) return 1'b0;
    return LSB ? w[idx] : w[n-1-idx];
  endfunction

  always @(negedge sclk or posedge ss)
    if (ss) falls <= 0;
    else    falls <= falls + 1;

  always @(negedge sclk2 or posedge ss2)
    if (ss2) falls2 <= 0;
    else     falls2 <= falls2 + 1;

  assign miso  = ss ? 1'b0 :
    pbit({32'b0, miso_word}, falls, 32);
  assign miso2 = ss2 ? 1'b0 :
    pbit({56'b0, miso_word2}, falls2, 8);

  // Frame monitor for the 32-bit instance.
  int          cyc = 0;
  int          ss_low = 0;
  int          ss_hi_run = 0;
  int          last_gap = 0;
  int          rises = 0;
  int          last_rise = 0;
  int          done_cnt = 0;
  bit          ss_p = 1'b1;
  bit          sclk_p = 1'b0;
  bit          spacing_bad = 1'b0;
  bit          rx_changed = 1'b0;
  logic [31:0] mon_word = '0;
  logic [31:0] rx_before = '0;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      ss_p = 1'b1;
      sclk_p = 1'b0;
      ss_low = 0;
      ss_hi_run = 0;
      rises = 0;
    end else begin
      if (!ss) begin
        if (ss_p) begin
          last_gap = ss_hi_run;
          ss_low = 0;
          rises = 0;
          mon_word = '0;
          spacing_bad = 1'b0;
          rx_changed = 1'b0;
          rx_before = rx_data;
        end
        ss_low++;
        if (sclk && !sclk_p) begin
          if (rises > 0 && (cyc - last_rise) != 8)
            spacing_bad = 1'b1;
          last_rise = cyc;
          rises++;
          mon_word = LSB ? {mosi, mon_word[31:1]}
                         : {mon_word[30:0], mosi};
        end
        if (rx_data !== rx_before) rx_changed = 1'b1;
      end else begin
        if (!ss_p) ss_hi_run = 0;
        ss_hi_run++;
      end
      if (done) begin
        done_cnt++;
        n_tests++;
        if (ss !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL done_ss_busy: ss=%b busy=%b, required 1/0",
                   ss, busy);
        end
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: done with no expected frame");
        end else begin
          e = sb.pop_front();
          if (mon_word !== e.tx) begin
            n_fail++;
            $display("FAIL mosi_word: got %h, required %h",
                     mon_word, e.tx);
          end
          n_tests++;
          if (rx_data !== e.rx) begin
            n_fail++;
            $display("FAIL rx_data: got %h, required %h",
                     rx_data, e.rx);
          end
          n_tests++;
          if (ss_low != 260) begin
            n_fail++;
            $display("FAIL ss_low_len: got %0d, required 260",
                     ss_low);
          end
          n_tests++;
          if (rises != 32) begin
            n_fail++;
            $display("FAIL sclk_rises: got %0d, required 32", rises);
          end
          n_tests++;
          if (spacing_bad) begin
            n_fail++;
            $display("FAIL sclk_spacing: got uneven, required 8");
          end
          n_tests++;
          if (rx_changed) begin
            n_fail++;
            $display("FAIL rx_hold: got change mid-frame, required hold");
          end
        end
      end
      ss_p = ss;
      sclk_p = sclk;
    end
  end

  task automatic wait_done(input int target, input int budget,
                           input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s timeout: done count %0d, required %0d",
               name, done_cnt, target);
    end
  endtask

  task automatic send(input logic [31:0] t, input logic [31:0] r);
    @(posedge clk);
    #1;
    start = 1'b1;
    tx_data = t;
    sb.push_back('{tx: t, rx: r});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ss !== 1'b1 || ss2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ss: got %b/%b, required 1", ss, ss2);
    end
    n_tests++;
    if (sclk !== 1'b0 || mosi !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_sclk_mosi: got %b/%b, required 0",
               sclk, mosi);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_done: got %b/%b, required 0",
               busy, done);
    end
    n_tests++;
    if (rx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rx: got %h, required 0", rx_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int d0 = done_cnt;
    miso_word = 32'h3C3C_C3C3;
    send(32'hBFFC_0000, 32'h3C3C_C3C3);
    wait_done(d0 + 1, 400, "basic");
    repeat (5) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d, required %0d",
               done_cnt - d0, 1);
    end
  endtask

  task automatic test_receive;
    int d0 = done_cnt;
    miso_word = 32'hA5A5_0F0F;
    send(32'h5A5A_1234, 32'hA5A5_0F0F);
    wait_done(d0 + 1, 400, "receive");
    @(negedge clk);
    n_tests++;
    if (rx_data !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL rx_after_done: got %h, required a5a50f0f",
               rx_data);
    end
  endtask

  task automatic test_busy_ignore;
    int d0 = done_cnt;
    miso_word = 32'h1357_9BDF;
    send(32'hC0FF_EE11, 32'h1357_9BDF);
    repeat (40) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_mid: got %b, required 1", busy);
    end
    start = 1'b1;
    tx_data = 32'h0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0 + 1, 400, "busy_ignore");
    repeat (300) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 + 1 || ss !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore_count: got %0d ss=%b, required 1 ss=1",
               done_cnt - d0, ss);
    end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    miso_word = 32'h0F1E_2D3C;
    @(posedge clk);
    #1;
    start = 1'b1;
    tx_data = 32'h8BAD_F00D;
    sb.push_back('{tx: 32'h8BAD_F00D, rx: 32'h0F1E_2D3C});
    @(posedge clk);
    #1;
    tx_data = 32'h1234_5678;
    sb.push_back('{tx: 32'h1234_5678, rx: 32'h0F1E_2D3C});
    wait_done(d0 + 1, 400, "b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0 + 2, 400, "b2b_second");
    n_tests++;
    if (last_gap != 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d, required 1", last_gap);
    end
  endtask

  task automatic test_reset_midframe;
    int d0 = done_cnt;
    int k = 0;
    miso_word = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b1;
    tx_data = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!(ss === 1'b0 && sclk === 1'b1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL midframe_wait timeout: got %0d cycles, required <50",
               k);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ss !== 1'b1 || sclk !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ss_sclk: got %b/%b, required 1/0",
               ss, sclk);
    end
    n_tests++;
    if (busy !== 1'b0 || rx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_busy_rx: got %b/%h, required 0/0",
               busy, rx_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 || ss !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d dones ss=%b, required 0 ss=1",
               done_cnt - d0, ss);
    end
  endtask

  task automatic test_small;
    int          k = 0;
    int          low = 0;
    int          r = 0;
    int          ones = 0;
    logic        first = 1'b0;
    logic        sp = 1'b0;
    logic [7:0]  w = '0;
    exp8_t       x;
    miso_word2 = 8'h01;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    tx2 = 8'h01;
    sb2.push_back('{tx: 8'h01, rx: 8'h01});
    @(posedge clk);
    #1;
    start2 = 1'b0;
    while (done2 !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
      if (ss2 === 1'b0) low++;
      if (sclk2 && !sp) begin
        if (r == 0) first = mosi2;
        r++;
        if (mosi2) ones++;
        w = LSB ? {mosi2, w[7:1]} : {w[6:0], mosi2};
      end
      sp = sclk2;
    end
    n_tests++;
    if (done2 !== 1'b1) begin
      n_fail++;
      $display("FAIL small timeout: got no done, required done");
    end
    n_tests++;
    if (low != 17) begin
      n_fail++;
      $display("FAIL small_ss_low: got %0d, required 17", low);
    end
    n_tests++;
    if (r != 8) begin
      n_fail++;
      $display("FAIL small_rises: got %0d, required 8", r);
    end
    n_tests++;
    if (first !== LSB || ones != 1) begin
      n_fail++;
      $display("FAIL small_first_bit: got %b ones=%0d, required %b 1",
               first, ones, LSB);
    end
    n_tests++;
    if (sb2.size() == 0) begin
      n_fail++;
      $display("FAIL small_sb_empty: got none, required one");
    end else begin
      x = sb2.pop_front();
      if (w !== x.tx || rx2 !== x.rx) begin
        n_fail++;
        $display("FAIL small_data: got %h/%h, required %h/%h",
                 w, rx2, x.tx, x.rx);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_receive;
    test_busy_ignore;
    test_back_to_back;
    test_reset_midframe;
    test_small;
    n_tests++;
    if (sb.size() != 0 || sb2.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d/%0d, required 0",
               sb.size(), sb2.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
